// File: rtl/sram_bus_ctrl_if.sv
// Pipeline-side request/ack bundle for the shared SRAM controller.
// The master side is the fetch/data ports; the slave side is sram_bus_ctrl.
interface sram_bus_ctrl_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        mem_req;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
      input  if_ack, if_rdata, mem_ack, mem_rdata
   );

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
      output if_ack, if_rdata, mem_ack, mem_rdata
   );
endinterface

// File: rtl/sram_bus_ctrl.sv
// Serialises fetch and data requests onto BaseRAM/ExtRAM with registered strobes.
// state   | meaning
// IDLE    | sample requests (mem beats if), latch port/addr/we/data/bank
// READ    | RD_CYCLES cycles of ce_n/oe_n low; pin data captured on the last edge
// WRITE   | setup, we_n low, hold; data driven the whole time
// DONE    | one-cycle ack to the served port, strobes inactive
module sram_bus_ctrl #(
   parameter int RD_CYCLES = 2,
   parameter int WR_CYCLES = 3
) (
   input  logic           clk,
   input  logic           reset,
   sram_bus_ctrl_if.slave bus,
   output logic [19:0]    base_ram_addr,
   output logic           base_ram_ce_n,
   output logic           base_ram_oe_n,
   output logic           base_ram_we_n,
   output logic [3:0]     base_ram_be_n,
   output logic [31:0]    base_data_o,
   output logic           base_data_oe,
   input  logic [31:0]    base_data_i,
   output logic [19:0]    ext_ram_addr,
   output logic           ext_ram_ce_n,
   output logic           ext_ram_oe_n,
   output logic           ext_ram_we_n,
   output logic [3:0]     ext_ram_be_n,
   output logic [31:0]    ext_data_o,
   output logic           ext_data_oe,
   input  logic [31:0]    ext_data_i
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
   typedef enum logic [1:0] {B_NONE, B_BASE, B_EXT} bank_t;

   localparam logic [7:0] RD_LOAD = 8'(RD_CYCLES - 1);
   localparam logic [7:0] WR_LOAD = 8'(WR_CYCLES - 1);

   function automatic bank_t decode(input logic [9:0] hi);
      if (hi == 10'h200) return B_BASE;
      if (hi == 10'h201) return B_EXT;
      return B_NONE;
   endfunction

   state_t      state_q, state_d;
   bank_t       bank_q, bank_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        port_q, port_d;
   logic [3:0]  we_q, we_d;
   logic        if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
   logic [31:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
   logic [19:0] base_addr_q, base_addr_d, ext_addr_q, ext_addr_d;
   logic [31:0] base_wdata_q, base_wdata_d, ext_wdata_q, ext_wdata_d;
   logic        base_ce_n_q, base_ce_n_d, base_oe_n_q, base_oe_n_d, base_we_n_q, base_we_n_d;
   logic        ext_ce_n_q, ext_ce_n_d, ext_oe_n_q, ext_oe_n_d, ext_we_n_q, ext_we_n_d;
   logic [3:0]  base_be_n_q, base_be_n_d, ext_be_n_q, ext_be_n_d;
   logic        base_doe_q, base_doe_d, ext_doe_q, ext_doe_d;

   logic        sel_mem, ack_nx, ce_n_nx, oe_n_nx, we_n_nx, doe_nx;
   logic [31:0] req_addr, rd_word;
   logic [3:0]  req_we, be_n_nx;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^req_addr[1:0];

   always_comb begin
      state_d      = state_q;
      bank_d       = bank_q;
      cnt_d        = cnt_q;
      port_d       = port_q;
      we_d         = we_q;
      if_rdata_d   = if_rdata_q;
      mem_rdata_d  = mem_rdata_q;
      base_addr_d  = base_addr_q;
      ext_addr_d   = ext_addr_q;
      base_wdata_d = base_wdata_q;
      ext_wdata_d  = ext_wdata_q;
      sel_mem      = 1'b0;
      req_addr     = 32'h0;
      req_we       = 4'h0;
      rd_word      = 32'h0;
      ack_nx       = 1'b0;
      ce_n_nx      = 1'b1;
      oe_n_nx      = 1'b1;
      we_n_nx      = 1'b1;
      be_n_nx      = 4'hF;
      doe_nx       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.mem_req || bus.if_req) begin
               sel_mem  = bus.mem_req;
               req_addr = sel_mem ? bus.mem_addr : bus.if_addr;
               req_we   = sel_mem ? bus.mem_we : 4'h0;
               port_d   = sel_mem;
               we_d     = req_we;
               bank_d   = decode(req_addr[31:22]);
               if (bank_d == B_BASE) base_addr_d = req_addr[21:2];
               if (bank_d == B_EXT)  ext_addr_d  = req_addr[21:2];
               ce_n_nx  = 1'b0;
               // Unmapped addresses pass through one strobe-less cycle before DONE.
               if (req_we == 4'h0) begin
                  state_d = S_READ;
                  cnt_d   = (bank_d == B_NONE) ? 8'd0 : RD_LOAD;
                  oe_n_nx = 1'b0;
                  be_n_nx = 4'h0;
               end else begin
                  state_d = S_WRITE;
                  cnt_d   = (bank_d == B_NONE) ? 8'd0 : WR_LOAD;
                  doe_nx  = 1'b1;
                  be_n_nx = ~req_we;
                  if (bank_d == B_BASE) base_wdata_d = bus.mem_wdata;
                  if (bank_d == B_EXT)  ext_wdata_d  = bus.mem_wdata;
               end
            end
         end
         S_READ: begin
            if (cnt_q == 8'd0) begin
               state_d = S_DONE;
               ack_nx  = 1'b1;
               if (bank_q == B_BASE) rd_word = base_data_i;
               if (bank_q == B_EXT)  rd_word = ext_data_i;
               if (port_q) mem_rdata_d = rd_word;
               else        if_rdata_d  = rd_word;
            end else begin
               cnt_d   = cnt_q - 8'd1;
               ce_n_nx = 1'b0;
               oe_n_nx = 1'b0;
               be_n_nx = 4'h0;
            end
         end
         S_WRITE: begin
            if (cnt_q == 8'd0) begin
               state_d = S_DONE;
               ack_nx  = 1'b1;
            end else begin
               cnt_d   = cnt_q - 8'd1;
               ce_n_nx = 1'b0;
               doe_nx  = 1'b1;
               be_n_nx = ~we_q;
               // Final write cycle is the hold cycle with we_n back high.
               we_n_nx = (cnt_d == 8'd0);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if_ack_d    = ack_nx && !port_d;
      mem_ack_d   = ack_nx && port_d;
      base_ce_n_d = (bank_d == B_BASE) ? ce_n_nx : 1'b1;
      base_oe_n_d = (bank_d == B_BASE) ? oe_n_nx : 1'b1;
      base_we_n_d = (bank_d == B_BASE) ? we_n_nx : 1'b1;
      base_be_n_d = (bank_d == B_BASE) ? be_n_nx : 4'hF;
      base_doe_d  = (bank_d == B_BASE) ? doe_nx  : 1'b0;
      ext_ce_n_d  = (bank_d == B_EXT)  ? ce_n_nx : 1'b1;
      ext_oe_n_d  = (bank_d == B_EXT)  ? oe_n_nx : 1'b1;
      ext_we_n_d  = (bank_d == B_EXT)  ? we_n_nx : 1'b1;
      ext_be_n_d  = (bank_d == B_EXT)  ? be_n_nx : 4'hF;
      ext_doe_d   = (bank_d == B_EXT)  ? doe_nx  : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         bank_q       <= B_NONE;
         cnt_q        <= 8'd0;
         port_q       <= 1'b0;
         we_q         <= 4'h0;
         if_ack_q     <= 1'b0;
         mem_ack_q    <= 1'b0;
         if_rdata_q   <= 32'h0;
         mem_rdata_q  <= 32'h0;
         base_addr_q  <= 20'h0;
         ext_addr_q   <= 20'h0;
         base_wdata_q <= 32'h0;
         ext_wdata_q  <= 32'h0;
         base_ce_n_q  <= 1'b1;
         base_oe_n_q  <= 1'b1;
         base_we_n_q  <= 1'b1;
         base_be_n_q  <= 4'hF;
         base_doe_q   <= 1'b0;
         ext_ce_n_q   <= 1'b1;
         ext_oe_n_q   <= 1'b1;
         ext_we_n_q   <= 1'b1;
         ext_be_n_q   <= 4'hF;
         ext_doe_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bank_q       <= bank_d;
         cnt_q        <= cnt_d;
         port_q       <= port_d;
         we_q         <= we_d;
         if_ack_q     <= if_ack_d;
         mem_ack_q    <= mem_ack_d;
         if_rdata_q   <= if_rdata_d;
         mem_rdata_q  <= mem_rdata_d;
         base_addr_q  <= base_addr_d;
         ext_addr_q   <= ext_addr_d;
         base_wdata_q <= base_wdata_d;
         ext_wdata_q  <= ext_wdata_d;
         base_ce_n_q  <= base_ce_n_d;
         base_oe_n_q  <= base_oe_n_d;
         base_we_n_q  <= base_we_n_d;
         base_be_n_q  <= base_be_n_d;
         base_doe_q   <= base_doe_d;
         ext_ce_n_q   <= ext_ce_n_d;
         ext_oe_n_q   <= ext_oe_n_d;
         ext_we_n_q   <= ext_we_n_d;
         ext_be_n_q   <= ext_be_n_d;
         ext_doe_q    <= ext_doe_d;
      end
   end

   assign bus.if_ack    = if_ack_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.mem_ack   = mem_ack_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign base_ram_addr = base_addr_q;
   assign base_ram_ce_n = base_ce_n_q;
   assign base_ram_oe_n = base_oe_n_q;
   assign base_ram_we_n = base_we_n_q;
   assign base_ram_be_n = base_be_n_q;
   assign base_data_o   = base_wdata_q;
   assign base_data_oe  = base_doe_q;
   assign ext_ram_addr  = ext_addr_q;
   assign ext_ram_ce_n  = ext_ce_n_q;
   assign ext_ram_oe_n  = ext_oe_n_q;
   assign ext_ram_we_n  = ext_we_n_q;
   assign ext_ram_be_n  = ext_be_n_q;
   assign ext_data_o    = ext_wdata_q;
   assign ext_data_oe   = ext_doe_q;
endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl: reset, reads, writes, arbitration, decode edges, reset mid-write.
// Simple SRAM models return address-derived data only while ce_n and oe_n are both low.
module tb_sram_bus_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] base_ram_addr, ext_ram_addr;
   logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_data_oe;
   logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, ext_data_oe;
   logic [3:0]  base_ram_be_n, ext_ram_be_n;
   logic [31:0] base_data_o, base_data_i, ext_data_o, ext_data_i;

   int n_cmp = 0;
   int n_err = 0;

   int          if_k, mem_k, if_n, mem_n, both_ack, bad_oe;
   int          b_ce, b_oe, b_we, b_doe, b_we_k, b_doe_k;
   int          e_ce, e_oe, e_we, e_doe, e_we_k, e_doe_k;
   logic [19:0] b_addr_s, e_addr_s;
   logic [3:0]  b_be_s, e_be_s;
   logic [31:0] b_do_s, e_do_s, if_rd_s, mem_rd_s;

   always #5 clk = ~clk;

   sram_bus_ctrl_if bus ();

   function automatic logic [31:0] base_model(input logic [19:0] a);
      return (a == 20'd1) ? 32'h1234_5678 : {12'hBA5, a};
   endfunction

   function automatic logic [31:0] ext_model(input logic [19:0] a);
      return {12'hE07, a};
   endfunction

   assign base_data_i = (!base_ram_ce_n && !base_ram_oe_n) ? base_model(base_ram_addr) : 32'hDEAD_BEEF;
   assign ext_data_i  = (!ext_ram_ce_n && !ext_ram_oe_n) ? ext_model(ext_ram_addr) : 32'hDEAD_BEEF;

   sram_bus_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .base_ram_addr (base_ram_addr),
      .base_ram_ce_n (base_ram_ce_n),
      .base_ram_oe_n (base_ram_oe_n),
      .base_ram_we_n (base_ram_we_n),
      .base_ram_be_n (base_ram_be_n),
      .base_data_o   (base_data_o),
      .base_data_oe  (base_data_oe),
      .base_data_i   (base_data_i),
      .ext_ram_addr  (ext_ram_addr),
      .ext_ram_ce_n  (ext_ram_ce_n),
      .ext_ram_oe_n  (ext_ram_oe_n),
      .ext_ram_we_n  (ext_ram_we_n),
      .ext_ram_be_n  (ext_ram_be_n),
      .ext_data_o    (ext_data_o),
      .ext_data_oe   (ext_data_oe),
      .ext_data_i    (ext_data_i)
   );

   // Runs ncyc cycles, sampling on the falling edge; k=1 is the cycle after the request edge.
   task automatic observe(input int ncyc);
      if_k = 0; mem_k = 0; if_n = 0; mem_n = 0; both_ack = 0; bad_oe = 0;
      b_ce = 0; b_oe = 0; b_we = 0; b_doe = 0; b_we_k = 0; b_doe_k = 0;
      e_ce = 0; e_oe = 0; e_we = 0; e_doe = 0; e_we_k = 0; e_doe_k = 0;
      b_addr_s = '0; e_addr_s = '0; b_be_s = '0; e_be_s = '0;
      b_do_s = '0; e_do_s = '0; if_rd_s = 32'hFFFF_FFFF; mem_rd_s = 32'hFFFF_FFFF;
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (!base_ram_ce_n) begin
            if (b_ce == 0) begin b_addr_s = base_ram_addr; b_be_s = base_ram_be_n; b_do_s = base_data_o; end
            b_ce++;
         end
         if (!base_ram_oe_n) b_oe++;
         if (!base_ram_we_n) begin if (b_we_k == 0) b_we_k = k; b_we++; end
         if (base_data_oe) begin if (b_doe_k == 0) b_doe_k = k; b_doe++; end
         if (!ext_ram_ce_n) begin
            if (e_ce == 0) begin e_addr_s = ext_ram_addr; e_be_s = ext_ram_be_n; e_do_s = ext_data_o; end
            e_ce++;
         end
         if (!ext_ram_oe_n) e_oe++;
         if (!ext_ram_we_n) begin if (e_we_k == 0) e_we_k = k; e_we++; end
         if (ext_data_oe) begin if (e_doe_k == 0) e_doe_k = k; e_doe++; end
         if ((base_data_oe && !base_ram_oe_n) || (ext_data_oe && !ext_ram_oe_n) || (base_data_oe && ext_data_oe))
            bad_oe++;
         if (bus.if_ack && bus.mem_ack) both_ack++;
         if (bus.if_ack) begin
            if_n++;
            if (if_k == 0) begin if_k = k; if_rd_s = bus.if_rdata; end
            bus.if_req = 1'b0;
         end
         if (bus.mem_ack) begin
            mem_n++;
            if (mem_k == 0) begin mem_k = k; mem_rd_s = bus.mem_rdata; end
            bus.mem_req = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.mem_req = 1'b0; bus.mem_we = '0; bus.mem_addr = '0; bus.mem_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n} !== 6'b111111) begin
         n_err++; $display("FAIL reset_strobes: got %b want 111111", {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}); end
      n_cmp++; if ({base_ram_be_n, ext_ram_be_n} !== 8'hFF) begin
         n_err++; $display("FAIL reset_be_n: got %h want ff", {base_ram_be_n, ext_ram_be_n}); end
      n_cmp++; if ({base_data_oe, ext_data_oe} !== 2'b00) begin
         n_err++; $display("FAIL reset_data_oe: got %b want 00", {base_data_oe, ext_data_oe}); end
      n_cmp++; if ({bus.if_ack, bus.mem_ack} !== 2'b00) begin
         n_err++; $display("FAIL reset_acks: got %b want 00", {bus.if_ack, bus.mem_ack}); end
      n_cmp++; if ({bus.if_rdata, bus.mem_rdata} !== 64'h0) begin
         n_err++; $display("FAIL reset_rdata: got %h want 0", {bus.if_rdata, bus.mem_rdata}); end
      n_cmp++; if ({base_ram_addr, ext_ram_addr, base_data_o, ext_data_o} !== 104'h0) begin
         n_err++; $display("FAIL reset_addr_data: got %h want 0", {base_ram_addr, ext_ram_addr, base_data_o, ext_data_o}); end
      reset = 1'b0;
   endtask

   task automatic test_if_read();
      bus.if_req = 1'b1; bus.if_addr = 32'h8000_0004;
      observe(5);
      n_cmp++; if (if_k !== 3) begin n_err++; $display("FAIL if_read_ack_cycle: got %0d want 3", if_k); end
      n_cmp++; if (if_n !== 1) begin n_err++; $display("FAIL if_read_ack_pulses: got %0d want 1", if_n); end
      n_cmp++; if (if_rd_s !== 32'h1234_5678) begin n_err++; $display("FAIL if_read_data: got %h want 12345678", if_rd_s); end
      n_cmp++; if (b_addr_s !== 20'd1) begin n_err++; $display("FAIL if_read_addr: got %h want 00001", b_addr_s); end
      n_cmp++; if (b_ce !== 2 || b_oe !== 2) begin n_err++; $display("FAIL if_read_strobe_cycles: got ce=%0d oe=%0d want 2/2", b_ce, b_oe); end
      n_cmp++; if (b_be_s !== 4'h0) begin n_err++; $display("FAIL if_read_be_n: got %h want 0", b_be_s); end
      n_cmp++; if (b_we + b_doe !== 0) begin n_err++; $display("FAIL if_read_no_write: got we=%0d oe=%0d want 0/0", b_we, b_doe); end
      n_cmp++; if (e_ce + e_oe + e_we + e_doe !== 0) begin n_err++; $display("FAIL if_read_ext_quiet: got %0d want 0", e_ce + e_oe + e_we + e_doe); end
   endtask

   task automatic test_mem_write();
      bus.mem_req = 1'b1; bus.mem_we = 4'b0011; bus.mem_addr = 32'h8040_0008; bus.mem_wdata = 32'hAABB_CCDD;
      observe(6);
      n_cmp++; if (mem_k !== 4) begin n_err++; $display("FAIL write_ack_cycle: got %0d want 4", mem_k); end
      n_cmp++; if (e_addr_s !== 20'd2) begin n_err++; $display("FAIL write_addr: got %h want 00002", e_addr_s); end
      n_cmp++; if (e_be_s !== 4'b1100) begin n_err++; $display("FAIL write_be_n: got %b want 1100", e_be_s); end
      n_cmp++; if (e_do_s !== 32'hAABB_CCDD) begin n_err++; $display("FAIL write_data: got %h want aabbccdd", e_do_s); end
      n_cmp++; if (e_we !== 1 || e_we_k !== 2) begin n_err++; $display("FAIL write_we_pulse: got count=%0d at=%0d want 1 at 2", e_we, e_we_k); end
      n_cmp++; if (e_doe !== 3 || e_doe_k !== 1 || e_ce !== 3) begin
         n_err++; $display("FAIL write_window: got oe=%0d from %0d ce=%0d want 3 from 1 ce=3", e_doe, e_doe_k, e_ce); end
      n_cmp++; if (e_oe !== 0 || bad_oe !== 0) begin n_err++; $display("FAIL write_oe_conflict: got oe_n_lo=%0d bad=%0d want 0/0", e_oe, bad_oe); end
      n_cmp++; if (b_ce + b_we + b_doe !== 0) begin n_err++; $display("FAIL write_base_quiet: got %0d want 0", b_ce + b_we + b_doe); end
   endtask

   task automatic test_priority();
      bus.if_req = 1'b1; bus.if_addr = 32'h8000_0020;
      bus.mem_req = 1'b1; bus.mem_we = 4'b0000; bus.mem_addr = 32'h8000_0010;
      observe(9);
      n_cmp++; if (mem_k !== 3) begin n_err++; $display("FAIL prio_mem_ack_cycle: got %0d want 3", mem_k); end
      n_cmp++; if (if_k !== 7) begin n_err++; $display("FAIL prio_if_ack_cycle: got %0d want 7", if_k); end
      n_cmp++; if (mem_rd_s !== 32'hBA50_0004) begin n_err++; $display("FAIL prio_mem_data: got %h want ba500004", mem_rd_s); end
      n_cmp++; if (if_rd_s !== 32'hBA50_0008) begin n_err++; $display("FAIL prio_if_data: got %h want ba500008", if_rd_s); end
      n_cmp++; if (both_ack !== 0 || b_ce !== 4) begin n_err++; $display("FAIL prio_serialise: got both=%0d ce=%0d want 0/4", both_ack, b_ce); end
   endtask

   task automatic test_unmapped();
      bus.mem_req = 1'b1; bus.mem_we = 4'b0000; bus.mem_addr = 32'h0000_1000;
      observe(4);
      n_cmp++; if (mem_k !== 2) begin n_err++; $display("FAIL unmapped_ack_cycle: got %0d want 2", mem_k); end
      n_cmp++; if (mem_rd_s !== 32'h0) begin n_err++; $display("FAIL unmapped_rdata: got %h want 0", mem_rd_s); end
      n_cmp++; if (b_ce + e_ce + b_oe + e_oe + b_doe + e_doe !== 0) begin
         n_err++; $display("FAIL unmapped_activity: got %0d want 0", b_ce + e_ce + b_oe + e_oe + b_doe + e_doe); end
   endtask

   task automatic test_map_edges();
      bus.if_req = 1'b1; bus.if_addr = 32'h8080_0000;
      observe(4);
      n_cmp++; if (if_k !== 2 || if_rd_s !== 32'h0) begin n_err++; $display("FAIL edge_above_ext: got ack=%0d data=%h want 2/0", if_k, if_rd_s); end
      n_cmp++; if (b_ce + e_ce !== 0) begin n_err++; $display("FAIL edge_above_ext_quiet: got %0d want 0", b_ce + e_ce); end
      bus.if_req = 1'b1; bus.if_addr = 32'h803F_FFFC;
      observe(5);
      n_cmp++; if (b_addr_s !== 20'hFFFFF || e_ce !== 0) begin n_err++; $display("FAIL edge_base_top: got addr=%h ext_ce=%0d want fffff/0", b_addr_s, e_ce); end
      n_cmp++; if (if_k !== 3 || if_rd_s !== 32'hBA5F_FFFF) begin n_err++; $display("FAIL edge_base_top_data: got ack=%0d data=%h want 3/ba5fffff", if_k, if_rd_s); end
   endtask

   task automatic test_back_to_back();
      bus.mem_req = 1'b1; bus.mem_we = 4'b0000; bus.mem_addr = 32'h8040_0008;
      observe(5);
      n_cmp++; if (mem_k !== 3 || mem_rd_s !== 32'hE070_0002) begin n_err++; $display("FAIL ext_read: got ack=%0d data=%h want 3/e0700002", mem_k, mem_rd_s); end
      n_cmp++; if (e_ce !== 2 || e_oe !== 2 || b_ce !== 0) begin n_err++; $display("FAIL ext_read_strobes: got ce=%0d oe=%0d base=%0d want 2/2/0", e_ce, e_oe, b_ce); end
      n_cmp++; if (bus.if_rdata !== 32'hBA5F_FFFF) begin n_err++; $display("FAIL if_rdata_held: got %h want ba5fffff", bus.if_rdata); end
   endtask

   task automatic test_reset_mid_write();
      bus.mem_req = 1'b1; bus.mem_we = 4'b1111; bus.mem_addr = 32'h8000_0040; bus.mem_wdata = 32'h0102_0304;
      @(posedge clk); @(negedge clk);
      n_cmp++; if ({base_ram_we_n, base_data_oe, base_ram_ce_n} !== 3'b110) begin
         n_err++; $display("FAIL rstw_setup: got we_n/oe/ce_n=%b want 110", {base_ram_we_n, base_data_oe, base_ram_ce_n}); end
      @(posedge clk); @(negedge clk);
      n_cmp++; if (base_ram_we_n !== 1'b0) begin n_err++; $display("FAIL rstw_we_low: got %b want 0", base_ram_we_n); end
      reset = 1'b1;
      bus.mem_req = 1'b0;
      @(posedge clk); @(negedge clk);
      n_cmp++; if ({base_ram_we_n, base_data_oe, base_ram_ce_n, base_ram_be_n} !== 7'b1011111) begin
         n_err++; $display("FAIL rstw_abort: got we_n/oe/ce_n/be_n=%b want 1011111", {base_ram_we_n, base_data_oe, base_ram_ce_n, base_ram_be_n}); end
      n_cmp++; if ({bus.mem_ack, bus.if_rdata, bus.mem_rdata} !== 65'h0) begin
         n_err++; $display("FAIL rstw_regs: got %h want 0", {bus.mem_ack, bus.if_rdata, bus.mem_rdata}); end
      reset = 1'b0;
      observe(5);
      n_cmp++; if (mem_n + if_n !== 0) begin n_err++; $display("FAIL rstw_no_ack: got %0d want 0", mem_n + if_n); end
      n_cmp++; if (b_ce + b_we + b_doe !== 0) begin n_err++; $display("FAIL rstw_idle: got %0d want 0", b_ce + b_we + b_doe); end
   endtask

   initial begin
      fork
         begin
            #200000;
            $display("FAIL timeout: simulation still running at %0t", $time);
            $fatal(1, "timeout");
         end
      join_none
      test_reset();
      test_if_read();
      test_mem_write();
      test_priority();
      test_unmapped();
      test_map_edges();
      test_back_to_back();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
